// File: rtl/seg_capture.sv
// Capture side of the multiplexed 7-segment bus: samples the active-low digit
// enables and segments and decodes each stable digit back to its 5-bit symbol code.
module seg_capture #(
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an_n,
  input  logic [7:0]  seg_n,
  output logic [39:0] codes,
  output logic [7:0]  valid,
  output logic        upd,
  output logic [2:0]  upd_digit,
  output logic        err,
  output logic        frame,
  output logic        stale
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE);
  localparam logic [CW-1:0] CNT_ACC  = CW'(STABLE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [7:0]    r_s_an;
  logic [7:0]    r_s_seg;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tmo;
  logic [4:0]    r_codes [8];
  logic [7:0]    r_valid;
  logic          r_upd;
  logic [2:0]    r_upd_digit;
  logic          r_err;
  logic          r_frame;
  logic          r_stale;

  logic          w_same;
  logic [CW-1:0] w_cnt_next;
  logic [7:0]    w_en;
  logic          w_one_hot;
  logic          w_accept;
  logic [2:0]    w_idx;
  logic [7:0]    w_bit;
  logic [7:0]    w_valid_acc;
  logic          w_bad;
  logic [4:0]    w_code;
  logic          w_timeout;

  // Returns {unknown, code}; 92 and 90 deliberately resolve to 5 and 9.
  function automatic logic [5:0] decode(input logic [7:0] seg);
    case (seg)
      8'hC0: decode = {1'b0, 5'd0};
      8'hF9: decode = {1'b0, 5'd1};
      8'hA4: decode = {1'b0, 5'd2};
      8'hB0: decode = {1'b0, 5'd3};
      8'h99: decode = {1'b0, 5'd4};
      8'h92: decode = {1'b0, 5'd5};
      8'h82: decode = {1'b0, 5'd6};
      8'hF8: decode = {1'b0, 5'd7};
      8'h80: decode = {1'b0, 5'd8};
      8'h90: decode = {1'b0, 5'd9};
      8'h88: decode = {1'b0, 5'd10};
      8'h83: decode = {1'b0, 5'd11};
      8'hC6: decode = {1'b0, 5'd12};
      8'hA1: decode = {1'b0, 5'd13};
      8'h86: decode = {1'b0, 5'd14};
      8'h8E: decode = {1'b0, 5'd15};
      8'hC7: decode = {1'b0, 5'd16};
      8'h87: decode = {1'b0, 5'd17};
      8'hAF: decode = {1'b0, 5'd19};
      8'h8B: decode = {1'b0, 5'd20};
      8'hAB: decode = {1'b0, 5'd21};
      8'h91: decode = {1'b0, 5'd23};
      8'h8C: decode = {1'b0, 5'd24};
      8'hE3: decode = {1'b0, 5'd25};
      8'hDC: decode = {1'b0, 5'd26};
      8'hA3: decode = {1'b0, 5'd27};
      8'h9D: decode = {1'b0, 5'd28};
      8'hFF: decode = {1'b0, 5'd31};
      default: decode = {1'b1, 5'd30};
    endcase
  endfunction

  // The run counter looks one sample ahead so the accept lands STABLE edges after the pins change.
  always_comb begin
    w_same = ({an_n, seg_n} == {r_s_an, r_s_seg});
    if (!w_same) begin
      w_cnt_next = '0;
    end else if (r_cnt == CNT_MAX) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + 1'b1;
    end
    w_en      = ~r_s_an;
    w_one_hot = (w_en != 8'd0) && ((w_en & (w_en - 8'd1)) == 8'd0);
    w_accept  = w_one_hot && (w_cnt_next == CNT_ACC);
    w_idx     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_en[i]) begin
        w_idx = 3'(i);
      end
    end
    {w_bad, w_code} = decode(r_s_seg);
    w_bit       = 8'd1 << w_idx;
    w_valid_acc = r_valid | w_bit;
    w_timeout   = (r_tmo == TMO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_an      <= 8'hFF;
      r_s_seg     <= 8'hFF;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_valid     <= 8'd0;
      r_upd       <= 1'b0;
      r_upd_digit <= 3'd0;
      r_err       <= 1'b0;
      r_frame     <= 1'b0;
      r_stale     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_codes[i] <= 5'd31;
      end
    end else begin
      r_s_an  <= an_n;
      r_s_seg <= seg_n;
      r_cnt   <= w_cnt_next;
      r_upd   <= w_accept;
      r_err   <= w_accept && w_bad;
      r_frame <= 1'b0;
      r_stale <= 1'b0;
      // An accept takes priority over a simultaneous timeout.
      if (w_accept) begin
        r_codes[w_idx] <= w_code;
        r_valid        <= w_valid_acc;
        r_upd_digit    <= w_idx;
        r_frame        <= (r_valid != 8'hFF) && (w_valid_acc == 8'hFF);
        r_tmo          <= '0;
      end else if (w_timeout) begin
        r_valid <= 8'd0;
        r_stale <= 1'b1;
        r_tmo   <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_codes
      assign codes[5*gi +: 5] = r_codes[gi];
    end
  endgenerate

  assign valid     = r_valid;
  assign upd       = r_upd;
  assign upd_digit = r_upd_digit;
  assign err       = r_err;
  assign frame     = r_frame;
  assign stale     = r_stale;

endmodule
